// File: rtl/pdm_mod_pkg.sv
// ============================================================================
// Module      : pdm_mod_pkg
// Description : Shared defaults, dither LFSR constants and accumulator sizing
//               for the PDM modulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pdm_mod_pkg;

    localparam int SAMPLE_BW_DEF = 8;
    localparam int OSR_DEF       = 64;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1: taps on bits 15,13,12,10
    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    function automatic int acc_width(input int sample_bw);
        return sample_bw + 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pdm_mod_fifo.sv
// ============================================================================
// Module      : pdm_mod_fifo
// Description : Two-entry synchronous FIFO with full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_mod_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count != 2'd0);
    // A pop on a full FIFO frees the slot for a same-cycle push
    assign do_push = push_i && ((count != 2'd2) || do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 2; i++) mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign data_o  = mem[rd_ptr];
    assign full_o  = (count == 2'd2);
    assign empty_o = (count == 2'd0);

endmodule

`default_nettype wire

// File: rtl/pdm_modulator.sv
// ============================================================================
// Module      : pdm_modulator
// Description : First-order sigma-delta PCM->PDM modulator for loopback/BIST.
//               Optional dither: define PDM_MODULATOR_DITHER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pdm_modulator
    import pdm_mod_pkg::*;
#(
    parameter int SAMPLE_BW = SAMPLE_BW_DEF,
    parameter int OSR       = OSR_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [SAMPLE_BW-1:0] pcm_data_i,
    input  logic                 pcm_valid_i,
    output logic                 pcm_ready_o,
    input  logic                 pdm_clk_i,
    output logic                 pdm_data_o,
    output logic                 underflow_o
);

    localparam int ACC_W = acc_width(SAMPLE_BW);
    localparam int CNT_W = $clog2(OSR);
    localparam logic signed [ACC_W-1:0] FS = ACC_W'(1) << (SAMPLE_BW - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

    logic                        pdm_clk_d;
    logic                        en_d;
    logic                        tick;
    logic                        load;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic        [SAMPLE_BW-1:0] fifo_data;
    logic signed [SAMPLE_BW-1:0] hold;
    logic signed [SAMPLE_BW-1:0] x_base;
    logic signed [SAMPLE_BW-1:0] x;
    logic signed [ACC_W-1:0]     x_ext;
    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     acc_next;
    logic                        bit_out;
    logic        [CNT_W-1:0]     cnt;
    logic                        armed;

    // en_d masks a falling edge that coincides with the enable rising
    assign tick      = en_i && en_d && pdm_clk_d && !pdm_clk_i;
    assign load      = tick && (cnt == '0);
    assign fifo_pop  = load && !fifo_empty;
    assign fifo_push = pcm_valid_i && !fifo_full;
    assign pcm_ready_o = !fifo_full;

    pdm_mod_fifo #(
        .WIDTH (SAMPLE_BW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (fifo_push),
        .data_i  (pcm_data_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign x_base = fifo_pop ? $signed(fifo_data) : hold;

`ifdef PDM_MODULATOR_DITHER_EN
    localparam logic signed [SAMPLE_BW:0] X_MAX = (SAMPLE_BW+1)'((1 << (SAMPLE_BW - 1)) - 1);
    localparam logic signed [SAMPLE_BW:0] X_MIN = -X_MAX - (SAMPLE_BW+1)'(1);

    logic [LFSR_W-1:0]         lfsr;
    logic signed [SAMPLE_BW:0] x_wide;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) lfsr <= LFSR_SEED;
        else if (tick) lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    end

    always_comb begin
        x_wide = {x_base[SAMPLE_BW-1], x_base};
        x_wide = lfsr[0] ? (x_wide + (SAMPLE_BW+1)'(1)) : (x_wide - (SAMPLE_BW+1)'(1));
        if (x_wide > X_MAX)      x = X_MAX[SAMPLE_BW-1:0];
        else if (x_wide < X_MIN) x = X_MIN[SAMPLE_BW-1:0];
        else                     x = x_wide[SAMPLE_BW-1:0];
    end
`else
    assign x = x_base;
`endif

    assign x_ext    = {{(ACC_W-SAMPLE_BW){x[SAMPLE_BW-1]}}, x};
    assign bit_out  = !acc[ACC_W-1];
    assign acc_next = acc + x_ext - (bit_out ? FS : -FS);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pdm_clk_d   <= 1'b0;
            en_d        <= 1'b0;
            hold        <= '0;
            armed       <= 1'b0;
            underflow_o <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            pdm_data_o  <= 1'b0;
        end else begin
            pdm_clk_d <= pdm_clk_i;
            en_d      <= en_i;
            if (fifo_push) armed <= 1'b1;
            if (fifo_pop) hold <= $signed(fifo_data);
            if (load && fifo_empty && armed) underflow_o <= 1'b1;
            if (!en_i) begin
                acc        <= '0;
                cnt        <= '0;
                pdm_data_o <= 1'b0;
            end else if (tick) begin
                pdm_data_o <= bit_out;
                acc        <= acc_next;
                cnt        <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pdm_modulator.sv
// ============================================================================
// Module      : tb_pdm_modulator
// Description : Self-checking bench: tick-level reference model plus directed
//               bit-pattern expectations for the PDM modulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pdm_modulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] pcm_data;
    logic       pcm_valid;
    logic       pcm_ready;
    logic       pdm_clk;
    logic       pdm_data;
    logic       underflow;

    int n_checks = 0;
    int n_fail   = 0;

    pdm_modulator dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_i        (en),
        .pcm_data_i  (pcm_data),
        .pcm_valid_i (pcm_valid),
        .pcm_ready_o (pcm_ready),
        .pdm_clk_i   (pdm_clk),
        .pdm_data_o  (pdm_data),
        .underflow_o (underflow)
    );

    always #5 clk = ~clk;

    // PDM clock: period of 4 system clocks, changed away from the active edge
    int pdiv = 0;
    always @(negedge clk) begin
        pdiv = pdiv + 1;
        if (pdiv == 2) begin
            pdiv    = 0;
            pdm_clk = ~pdm_clk;
        end
    end

    // ---------------- reference model (tick level, integer arithmetic) -----
    int m_q[$];
    int m_hold, m_acc, m_cnt;
    bit m_armed, m_uf, m_bit, m_pclk_d, m_en_d;
    int m_ticks = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_hold = 0; m_acc = 0; m_cnt = 0;
            m_armed = 0; m_uf = 0; m_bit = 0; m_pclk_d = 0; m_en_d = 0;
        end else begin
            bit push, tick;
            push = pcm_valid && (m_q.size() < 2);
            tick = en && m_en_d && m_pclk_d && !pdm_clk;
            if (tick && m_cnt == 0) begin
                if (m_q.size() > 0) m_hold = m_q.pop_front();
                else if (m_armed)   m_uf = 1;
            end
            if (push) begin
                m_q.push_back(int'($signed(pcm_data)));
                m_armed = 1;
            end
            if (!en) begin
                m_acc = 0; m_cnt = 0; m_bit = 0;
            end else if (tick) begin
                m_bit = (m_acc >= 0);
                m_acc = m_acc + m_hold - (m_bit ? 128 : -128);
                m_cnt = (m_cnt + 1) % 64;
                m_ticks++;
            end
            m_pclk_d = pdm_clk;
            m_en_d   = en;
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare and per-tick logging ---------------
    bit bits_q[$];
    bit uf_q[$];
    int seen_ticks = 0;
    int pushes = 0;

    always @(negedge clk) begin
        chk("pdm_data_o", pdm_data, m_bit);
        chk("pcm_ready_o", pcm_ready, m_q.size() < 2);
        chk("underflow_o", underflow, m_uf);
        if (rst_n && pcm_valid && pcm_ready) pushes++;
        if (m_ticks != seen_ticks) begin
            seen_ticks = m_ticks;
            bits_q.push_back(pdm_data);
            uf_q.push_back(underflow);
        end
    end

    task automatic wait_ticks(input int n);
        int start = m_ticks;
        int budget = 8 * n + 40;
        while ((m_ticks - start) < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_checks++; n_fail++;
            $display("FAIL tick_timeout: got %0d ticks, expected %0d", m_ticks - start, n);
        end
        @(negedge clk);
    endtask

    function automatic int ones(input int n);
        int s = 0;
        for (int i = 0; i < n && i < bits_q.size(); i++) s += bits_q[i];
        return s;
    endfunction

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        en = 1'b0; pcm_valid = 1'b0; pcm_data = 8'h00;
        repeat (6) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_run();
        bits_q.delete(); uf_q.delete();
        pushes = 0;
        en = 1'b1;
    endtask

    task automatic fill(input logic [7:0] d);
        pcm_data = d; pcm_valid = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; pcm_valid = 1'b0; pcm_data = 8'h00; pdm_clk = 1'b0;
        // Reset with pdm_clk toggling and enable high
        repeat (10) @(negedge clk);
        chk("rst_pdm", pdm_data, 1'b0);
        chk("rst_ready", pcm_ready, 1'b1);
        chk("rst_uf", underflow, 1'b0);
        en = 1'b0;
        @(posedge clk); #2; rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Zero input
        fill(8'h00);
        start_run();
        wait_ticks(256);
        chk_int("zero_len", (bits_q.size() >= 256), 1);
        if (bits_q.size() >= 4) begin
            chk("zero_b0", bits_q[0], 1'b1);
            chk("zero_b1", bits_q[1], 1'b0);
            chk("zero_b2", bits_q[2], 1'b1);
            chk("zero_b3", bits_q[3], 1'b0);
        end
        chk_int("zero_ones256", ones(256), 128);

        // Enable dropped for 10 cycles with producer stalled
        pcm_valid = 1'b0;
        @(negedge clk);
        en = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("en_off_pdm", pdm_data, 1'b0);
        end
        chk("en_off_fifo_kept", pcm_ready, 1'b0);
        start_run();
        wait_ticks(2);
        if (bits_q.size() >= 2) begin
            chk("reen_b0", bits_q[0], 1'b1);
            chk("reen_b1", bits_q[1], 1'b0);
        end

        // Full-scale negative
        do_reset();
        fill(8'h80);
        start_run();
        wait_ticks(256);
        if (bits_q.size() >= 1) chk("neg_b0", bits_q[0], 1'b1);
        chk_int("neg_ones256", ones(256), 1);

        // Near full-scale positive
        do_reset();
        fill(8'h7F);
        start_run();
        wait_ticks(256);
        n_checks++;
        if (ones(256) < 254 || ones(256) > 256) begin
            n_fail++;
            $display("FAIL pos_ones_range: got %0d, expected 254..256", ones(256));
        end
        chk_int("pos_ones256", ones(256), 255);
        chk_int("pos_pushes", pushes, 4);

        // Underflow: two samples, then stall
        do_reset();
        pcm_data = 8'd64; pcm_valid = 1'b1;
        @(negedge clk);
        pcm_data = 8'd0;
        @(negedge clk);
        pcm_valid = 1'b0;
        @(negedge clk);
        start_run();
        wait_ticks(140);
        if (uf_q.size() >= 129) begin
            chk("uf_tick127", uf_q[127], 1'b0);
            chk("uf_tick128", uf_q[128], 1'b1);
        end else begin
            chk_int("uf_len", uf_q.size(), 129);
        end
        pcm_data = 8'h80; pcm_valid = 1'b1;
        wait_ticks(70);
        chk("uf_sticky", underflow, 1'b1);

        // Reset pulse mid-sample: outputs clear immediately
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pdm", pdm_data, 1'b0);
        chk("midrst_ready", pcm_ready, 1'b1);
        chk("midrst_uf", underflow, 1'b0);
        pcm_valid = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2; rst_n = 1'b1;
        fill(8'h00);
        start_run();
        wait_ticks(4);
        if (bits_q.size() >= 1) chk("post_rst_b0", bits_q[0], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pdm_modulator.md
# pdm_modulator

First-order sigma-delta modulator that acts as the transmitting end of the PDM microphone interface. It takes PCM samples over a valid/ready stream and drives a 1-bit PDM stream on the PDM clock that the wakey_wakey core provides. Used in the user project as an on-chip microphone stand-in for loopback/BIST of the decimation front end. It is driven from the Wishbone clock domain.

## Interface
- SAMPLE_BW, 8: signed PCM sample width.
- OSR, 64: PDM ticks per PCM sample (≥2).
- clk_i  input  1  system clock (wb_clk_i).
- rst_n_i  input  1  asynchronous, active-low reset.
- en_i  input  1  modulator enable.
- pcm_data_i  input  SAMPLE_BW  signed PCM sample.
- pcm_valid_i  input  1  sample valid.
- pcm_ready_o  output  1  buffer can accept a sample.
- pdm_clk_i  input  1  PDM clock; generated synchronously in clk_i domain.
- pdm_data_o  output  1  PDM bit, updated after pdm_clk_i falling edge.
- underflow_o  output  1  sticky: sample needed but buffer empty.

## Operation
- Reset values: pdm_data_o=0, pcm_ready_o=1 (buffer empty), underflow_o=0. Internal state clears: acc=0, tick counter=0, hold register=0, armed=0.
- Input buffer: 2-entry FIFO. A sample is accepted when pcm_valid_i && pcm_ready_o. pcm_ready_o = !full. The first accepted sample sets armed.
- Tick: a pdm_clk_i falling edge, detected against a one-cycle delayed copy of pdm_clk_i. Ticks are processed only while en_i=1.
- Sample load happens at a tick with counter==0:
  - FIFO non-empty: pop into the hold register.
  - FIFO empty: keep the hold register. Set underflow_o if armed.
- Counter: increments per tick and wraps OSR-1→0.
- Modulator, per tick, with FS = 2^(SAMPLE_BW-1):
  - bit = (acc ≥ 0).
  - acc ← acc + x − (bit ? FS : −FS).
  - x is the hold value after any load on this tick.
- Arithmetic: acc is signed SAMPLE_BW+2 bits. It stays within [−2FS, 2FS), so there is no saturation logic.
- en_i=0: acc, counter and pdm_data_o are forced to 0. FIFO contents and underflow_o are retained. Ticks are ignored.
- underflow_o clears only on reset.

## Timing
- Edge detection: falling edge seen at cycle N, so the tick is processed at N+1.
- pdm_data_o updates at N+1 and then holds until the next tick. This gives the receiver a full half-period of setup before its rising-edge sample.
- pcm_ready_o is registered-full based. A push and a pop in the same cycle on a full FIFO is allowed; the pop frees the slot.
- The same-cycle load is visible in x on the tick it occurs.
- Reset asserted mid-stream: all state clears immediately, with no partial bit. The first bit after release and enable is 1.
- A pdm_clk_i edge coincident with an en_i rise is ignored. Processing starts on the next falling edge.

## Configuration
- PDM_MODULATOR_DITHER_EN defined:
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) advances once per tick.
  - Its LSB adds +1 or −1 to x, saturated to the SAMPLE_BW range.
  - This breaks idle tones.
- Undefined: no LFSR exists and the modulator is fully deterministic. The test plan bit patterns assume this case.

## Structure
- Package pdm_mod_pkg holds:
  - defaults for SAMPLE_BW and OSR;
  - the LFSR width, taps and seed;
  - a function computing acc width from SAMPLE_BW.
- Sub-module pdm_mod_fifo: a 2-entry, parameterized-width synchronous FIFO with full/empty flags and the same clock/reset ports.

## Test plan
- Reset: hold rst_n_i low with pdm_clk_i toggling, then release.
  - Required: pdm_data_o=0, pcm_ready_o=1, underflow_o=0 throughout reset and until the first enabled tick.
- Zero input: push x=0 continuously, en_i=1.
  - Required: pdm_data_o sequence 1,0,1,0,… from the first tick.
  - Required: exactly 128 ones per 256 ticks.
- Full-scale negative: push x=−128 (SAMPLE_BW=8).
  - Required: first bit 1, then all zeros.
- Near full-scale positive: push x=+127.
  - Required: ones count over 256 ticks is between 254 and 256.
  - Required: pcm_ready_o frees one slot every 64 ticks (OSR=64).
- Underflow: push 2 samples, then stall the producer.
  - Required: underflow_o rises at tick 128 (the third load).
  - Required: the last sample keeps modulating and underflow_o stays high after new pushes.
- Mid-stream control:
  - en_i dropped for 10 cycles: pdm_data_o=0 and, after re-enable, the bits restart at 1 while FIFO contents are kept.
  - Reset pulse mid-sample: all outputs return to their reset values within the same cycle.
